mult_div_unit: RTL

Multi-cycle multiply/divide unit that sits directly downstream of `Registerfiles` in the MIPS datapath. It consumes `rs_data` and `rt_data` and produces the architectural HI/LO registers used by MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO. It uses a shift-add multiplier and a restoring divider, one bit per cycle. The single-cycle core treats `busy` as a stall request and reads HI/LO combinationally for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - shift-add multiplier / restoring divider producing MIPS HI/LO
// Optional macro MDU_SIGNED_EN enables signed MULT/DIV; without it op[0] is ignored.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic [WIDTH-1:0]   a;
    logic [2*WIDTH-1:0] p;

    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     rsh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] p_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifdef MDU_SIGNED_EN
    logic rs_neg;
    logic rt_neg;
    logic neg_res;
    logic neg_rem;

    always_comb begin
        rs_neg = op[0] & rs_data[WIDTH-1];
        rt_neg = op[0] & rt_data[WIDTH-1];
        rs_mag = rs_neg ? -rs_data : rs_data;
        rt_mag = rt_neg ? -rt_data : rt_data;
    end

    // A zero divisor keeps the all-ones quotient un-negated; the remainder
    // sign fix-up then restores the original dividend bits into HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (state != RUN && start) begin
            neg_res <= (rs_neg ^ rt_neg) & (~op[1] | (|rt_data));
            neg_rem <= rs_neg;
        end
    end
`else
    logic unused_op0;
    assign unused_op0 = op[0];

    always_comb begin
        rs_mag = rs_data;
        rt_mag = rt_data;
    end
`endif

    // p holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        msum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : '0);
        rsh  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        diff = rsh - {1'b0, a};
        if (!is_div)
            p_next = {msum, p[WIDTH-1:1]};
        else if (!diff[WIDTH])
            p_next = {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        else
            p_next = {rsh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
        prod = p_next;
        quo  = p_next[WIDTH-1:0];
        rem  = p_next[2*WIDTH-1:WIDTH];
`ifdef MDU_SIGNED_EN
        if (neg_res) begin
            prod = -p_next;
            quo  = -p_next[WIDTH-1:0];
        end
        if (neg_rem)
            rem = -p_next[2*WIDTH-1:WIDTH];
`endif
        res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo = is_div ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            a      <= '0;
            p      <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        is_div <= op[1];
                        a      <= op[1] ? rt_mag : rs_mag;
                        p      <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    p   <= p_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
